// File: rtl/pipe_adder.sv
// pipe_adder: pipelined two's-complement adder with a valid/ready stream
// interface. The carry chain is cut into STAGES registered segments of
// CW = ceil(WIDTH/STAGES) bits. Skew registers carry the operand bits that
// have not been added yet. Deskew registers carry the sum bits that are
// already finished. The result is the exact WIDTH+1-bit signed sum.
//
// Optional feature: define PIPE_ADDER_SUB_EN to add the `sub` port.
// When sub = 1 the adder computes a - b (~b with carry-in 1). Without the
// macro the block only adds.

module pipe_adder #(
    parameter int WIDTH  = 10,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);

    localparam int CW = (WIDTH + STAGES - 1) / STAGES;

    // Per-stage pipeline registers
    logic [WIDTH-1:0] a_r [STAGES];
    logic [WIDTH-1:0] b_r [STAGES];
    logic [WIDTH:0]   s_r [STAGES];
    logic             c_r [STAGES];
    logic             v_r [STAGES];

    // Stage inputs: the ports for stage 0, the previous stage's registers otherwise
    logic [WIDTH-1:0] in_a_s [STAGES];
    logic [WIDTH-1:0] in_b_s [STAGES];
    logic [WIDTH:0]   in_s_s [STAGES];
    logic             in_c_s [STAGES];
    logic             in_v_s [STAGES];

    // Stage results
    logic [WIDTH:0]   nxt_s_s [STAGES];
    logic             nxt_c_s [STAGES];

    logic             advance_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_s;

    // Global stall: the whole pipe moves only when the output slot can drain
    always_comb begin
        advance_s = !v_r[STAGES-1] || out_ready;
    end

    assign in_ready  = advance_s;
    assign out_valid = v_r[STAGES-1];
    assign sum       = s_r[STAGES-1];

    // Operand conditioning for stage 0: invert b and force carry-in for subtraction
    always_comb begin
`ifdef PIPE_ADDER_SUB_EN
        b_eff_s = sub ? ~b : b;
        cin_s   = sub;
`else
        b_eff_s = b;
        cin_s   = 1'b0;
`endif
    end

    // Route each stage's input from the ports (stage 0) or the prior stage
    always_comb begin
        in_a_s[0] = a;
        in_b_s[0] = b_eff_s;
        in_s_s[0] = '0;
        in_c_s[0] = cin_s;
        in_v_s[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            in_a_s[k] = a_r[k-1];
            in_b_s[k] = b_r[k-1];
            in_s_s[k] = s_r[k-1];
            in_c_s[k] = c_r[k-1];
            in_v_s[k] = v_r[k-1];
        end
    end

    // Ripple-add each stage's segment; the last stage also forms the sign bit
    always_comb begin
        logic [WIDTH-1:0] ai_v;
        logic [WIDTH-1:0] bi_v;
        logic [WIDTH:0]   si_v;
        logic             ci_v;
        logic             seg_v;
        ai_v  = '0;
        bi_v  = '0;
        si_v  = '0;
        ci_v  = 1'b0;
        seg_v = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            ai_v = in_a_s[k];
            bi_v = in_b_s[k];
            si_v = in_s_s[k];
            ci_v = in_c_s[k];
            for (int i = 0; i < WIDTH; i++) begin
                seg_v   = (i >= k * CW) && (i < (k + 1) * CW);
                si_v[i] = seg_v ? (ai_v[i] ^ bi_v[i] ^ ci_v) : si_v[i];
                ci_v    = seg_v ? ((ai_v[i] & bi_v[i]) | (ci_v & (ai_v[i] ^ bi_v[i]))) : ci_v;
            end
            si_v[WIDTH] = (k == STAGES - 1) ? (ai_v[WIDTH-1] ^ bi_v[WIDTH-1] ^ ci_v) : si_v[WIDTH];
            nxt_s_s[k]  = si_v;
            nxt_c_s[k]  = ci_v;
        end
    end

    // Pipeline registers: cleared on reset, advance together, hold on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
                c_r[k] <= 1'b0;
                v_r[k] <= 1'b0;
            end
        end else if (advance_s) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= in_a_s[k];
                b_r[k] <= in_b_s[k];
                s_r[k] <= nxt_s_s[k];
                c_r[k] <= nxt_c_s[k];
                v_r[k] <= in_v_s[k];
            end
        end
    end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined two's-complement adder with a valid/ready stream interface. It generalises the fixed 10-bit ripple-carry adder with sign-extended 11-bit result to any operand width. The carry chain is split into `STAGES` registered segments, so long operands close timing. It sits between operand producers and accumulation/compare logic in the datapath and returns the exact `WIDTH+1`-bit signed sum.

## Interface
- `WIDTH`, 10, operand width in bits (signed); legal range 2..64
- `STAGES`, 2, number of pipeline segments the carry chain is cut into; legal range 1..`WIDTH`

- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low
- `in_valid`  in  1  operand pair present
- `in_ready`  out  1  pipeline accepts operands this cycle
- `a`  in  `WIDTH`  operand A, two's complement
- `b`  in  `WIDTH`  operand B, two's complement
- `sub`  in  1  0 = A+B, 1 = A−B; present only with `PIPE_ADDER_SUB_EN`
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts result
- `sum`  out  `WIDTH+1`  exact signed result

## Operation
- Segment width `CW` = ceil(`WIDTH`/`STAGES`). Stage k adds bits [k·CW, min((k+1)·CW, WIDTH)−1] plus the registered carry from stage k−1. Stage 0 carry-in = 0 (or `sub`).
- Skew registers carry the not-yet-added upper operand bits forward one stage per cycle. Deskew registers carry the finished lower sum bits forward, so all bits of `sum` belong to the same transaction.
- The final stage also produces `sum[WIDTH]` = a_ext ^ b_ext ^ carry-out, where a_ext = `a[WIDTH-1]` and b_ext = `b[WIDTH-1]` (sign extension). The result never overflows.
- Each stage holds one valid bit. Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- Global stall. advance = !`out_valid` || `out_ready`. When advance = 0, every stage register holds, including data, carries and valid bits.
- `in_ready` = advance. It is combinational from `out_ready` by design.
- Bubbles are not collapsed. An empty stage still consumes one cycle of latency.
- `out_valid` and `sum` come directly from last-stage registers. There is no combinational path from `a`/`b` to `sum`.

## Timing
- Reset (`rst_n` low, any time): all valid bits and `out_valid` = 0, and `sum` = 0. All carry, skew and deskew registers = 0. `in_ready` = 1 while in reset-released idle.
- Reset mid-operation: all in-flight transactions are discarded and none is emitted after release. The first transaction accepted after release completes normally.
- Latency: a transaction accepted at edge N has `out_valid` = 1 after edge N+`STAGES−1`. The result is visible in cycle N+`STAGES`, provided there are no stalls.
- Throughput: one transaction per cycle while `out_ready` = 1.
- Held output: while `out_valid` = 1 and `out_ready` = 0, `sum` is stable and nothing is accepted.
- Accept and emit in the same cycle are permitted and required for full throughput.
- `STAGES` = 1: single register stage, latency 1.

## Configuration
- `PIPE_ADDER_SUB_EN` defined:
  - `sub` port exists and is captured with the operands.
  - When `sub` = 1, stage 0 uses ~`b` and carry-in 1. The sign extension uses ~`b[WIDTH-1]`.
  - `sum` = a − b, exact in `WIDTH+1` bits.
  - `sub` travels with its transaction; changing it mid-stream affects only new transactions.
- Not defined: no `sub` port, no inversion logic, add only.

## Test plan
- `WIDTH`=10, `STAGES`=2, add: a=511, b=511 → `sum`=11'h3FE (1022), `out_valid` 2 cycles after accept.
- Add: a=10'h200 (−512), b=10'h200 → `sum`=11'h400 (−1024); a=10'h3FF (−1), b=1 → `sum`=0, including carry across the segment boundary.
- Back-to-back with backpressure:
  - Stimulus: 4 transactions (1+2, 3+4, 5+6, 7+8); `out_ready` low for 3 cycles starting at first `out_valid`.
  - Response: results 3, 7, 11, 15 emitted in order, none lost or duplicated; `in_ready` low during the stall.
- Reset mid-operation: assert `rst_n` low with 2 transactions in flight → `out_valid`=0, `sum`=0 immediately. After release, only the next accepted transaction (e.g. 100+23 → 123) is emitted.
- `WIDTH`=13, `STAGES`=4 (uneven segments), randomized 1000 pairs → `sum` matches sign-extended a+b.
- With `PIPE_ADDER_SUB_EN`:
  - a=10'h200 (−512), b=511, `sub`=1 → `sum`=11'h401 (−1023).
  - Alternate `sub` each cycle → each result uses its own `sub`.
